cv32e40x_tb_virt_periph: RTL and testbench
==========================================

// Module: cv32e40x_tb_virt_periph
// PURPOSE
//  Memory-mapped testbench peripheral on the core data bus, beside the dp RAM inside the TB wrapper.
//  Decodes stores and loads to a small register window.
//  Produces the pass/fail/exit status consumed by the top-level harness.
//  Buffers stdout characters and provides a countdown timer interrupt.
// PARAMETERS
//  BASE_ADDR   32'h2000_0000  window base; 32 B aligned; offsets in tb_vp_pkg
//  FIFO_DEPTH  8              print character buffer depth; power of 2, >=2
//  PASS_MAGIC  32'd123456789  TEST_STATUS value meaning pass; any other nonzero value means fail
// PORTS
//  core_clk        in   1   clock
//  core_rst_n      in   1   async active-low reset
//  data_req_i      in   1   OBI request, already address-selected for this window by the wrapper
//  data_gnt_o      out  1   OBI grant (combinational)
//  data_addr_i     in   32  byte address
//  data_we_i       in   1   1=store
//  data_be_i       in   4   byte enables
//  data_wdata_i    in   32  store data
//  data_rvalid_o   out  1   response valid
//  data_rdata_o    out  32  load data
//  print_valid_o   out  1   character available
//  print_ready_i   in   1   consumer accepts character
//  print_char_o    out  8   character
//  irq_timer_o     out  1   timer interrupt (level)
//  tests_passed_o  out  1   sticky pass
//  tests_failed_o  out  1   sticky fail
//  exit_valid_o    out  1   sticky exit
//  exit_value_o    out  32  exit code, valid with exit_valid_o
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; timer and cycle counter 0; rdata 0.
//  Handshake: gnt = req, except PRINT store with FIFO full -> gnt=0 until a slot frees.
//   Request accepted on req&gnt. rvalid asserts exactly 1 cycle later for 1 cycle, loads and stores alike.
//   Back-to-back accepts are legal: at most one response is outstanding.
//   addr/we/wdata are sampled only at accept.
//  Offsets (addr[4:0]); unmapped offsets: stores ignored, loads return 0.
//   0x00 PRINT W: push wdata[7:0] when be[0]=1. R: {24'b0, FIFO count}.
//   0x04 TEST_STATUS W: ==PASS_MAGIC -> tests_passed_o=1, else nonzero -> tests_failed_o=1, 0 ignored.
//   0x08 EXIT W: exit_value_o<=wdata; exit_valid_o<=1 in the following cycle. Later EXIT writes ignored.
//   0x0C TIMER W: load countdown=wdata; clears irq_timer_o. R: current countdown.
//   0x10 CYCLE R: free-running 32-bit cycle counter, wraps 0xFFFF_FFFF->0. W ignored.
//  Status: pass/fail/exit flags are sticky until reset. Pass and fail may both be set.
//  Timer:
//   Countdown decrements each cycle while nonzero.
//   The 1->0 transition sets irq_timer_o, which holds until the next TIMER write.
//   Writing 0 leaves the timer idle and clears irq.
//   A TIMER write in the same cycle as expiry wins: the new load is taken and irq stays 0.
//  Print FIFO:
//   Pop on print_valid_o&print_ready_i; print_char_o is the head entry.
//   Push and pop in the same cycle while full are legal only if gnt was given; count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//   No combinational path from print_ready_i to data_gnt_o. gnt uses registered full only.
//  Reset mid-transaction: a pending rvalid is dropped and FIFO contents are lost.
//   Requests during reset are not granted.
// STRUCTURE
//  tb_vp_pkg: offset localparams (OFS_PRINT..OFS_CYCLE), PASS_MAGIC default, vp_reg_e enum.
//  Sub-module tb_char_fifo: sync FIFO with push/pop, full/empty/count outputs.
//  Top level contains the decode, response register, timer, cycle counter and status flags.
// TESTING
//  Store 0x04=123456789 -> tests_passed_o=1 next cycle; tests_failed_o stays 0; rvalid 1 cycle after gnt.
//  Store 0x08=0x2A -> exit_valid_o=1, exit_value_o=0x2A; then store 0x08=0 -> value stays 0x2A.
//  9 PRINT stores, print_ready_i=0, FIFO_DEPTH=8 -> 9th store gnt=0.
//   Raise ready -> 9th store granted.
//   Chars emitted in order 'A'..'I', one per cycle.
//  Store TIMER=3 -> irq_timer_o rises 3 cycles after accept.
//   Store TIMER=0 -> irq_timer_o=0.
//   TIMER write coincident with expiry -> irq stays 0.
//  Load 0x10 twice, 5 cycles apart -> difference 5. Load 0x14 -> 0. Store 0x14 -> no state change.
//  Assert reset with a load accepted -> no rvalid; all outputs 0. Post-reset PRINT read -> 0.

Source files
------------

// File: rtl/cv32e40x_tb_virt_periph_pkg.sv
// Register map and shared types for the testbench virtual peripheral.
// The window is 32 bytes; only the low five address bits select a register.
package tb_vp_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT  = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC_DEFAULT = 32'd123456789;
    localparam int          FIFO_DEPTH_DEFAULT = 8;

    localparam logic [4:0] OFS_PRINT       = 5'h00;
    localparam logic [4:0] OFS_TEST_STATUS = 5'h04;
    localparam logic [4:0] OFS_EXIT        = 5'h08;
    localparam logic [4:0] OFS_TIMER       = 5'h0C;
    localparam logic [4:0] OFS_CYCLE       = 5'h10;

    typedef enum logic [2:0] {
        VP_PRINT,
        VP_TEST_STATUS,
        VP_EXIT,
        VP_TIMER,
        VP_CYCLE,
        VP_UNMAPPED
    } vp_reg_e;

    function automatic vp_reg_e decode_offset(input logic [4:0] ofs);
        vp_reg_e sel;
        case (ofs)
            OFS_PRINT:       sel = VP_PRINT;
            OFS_TEST_STATUS: sel = VP_TEST_STATUS;
            OFS_EXIT:        sel = VP_EXIT;
            OFS_TIMER:       sel = VP_TIMER;
            OFS_CYCLE:       sel = VP_CYCLE;
            default:         sel = VP_UNMAPPED;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cv32e40x_tb_virt_periph_char_fifo.sv
// Synchronous character FIFO feeding the harness stdout stream.
// Head entry is presented combinationally; full/empty derive from the registered count only.
module tb_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       core_clk,
    input  logic                       core_rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("tb_char_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40x_tb_virt_periph.sv
// Memory-mapped testbench peripheral: stdout buffer, pass/fail/exit status,
// countdown timer interrupt and a free-running cycle counter on the OBI data bus.
module cv32e40x_tb_virt_periph
    import tb_vp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEFAULT
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        print_valid_o,
    input  logic        print_ready_i,
    output logic [7:0]  print_char_o,
    output logic        irq_timer_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    generate
        if (BASE_ADDR[4:0] != 5'd0) begin : g_bad_base
            $error("cv32e40x_tb_virt_periph: BASE_ADDR must be 32-byte aligned");
        end
    endgenerate

    vp_reg_e     sel;
    logic        accept;
    logic        wr;
    logic        rd;
    logic        print_store;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]  fifo_head;
    logic [31:0] read_data;

    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic        passed_reg;
    logic        failed_reg;
    logic        exit_valid_reg;
    logic [31:0] exit_value_reg;
    logic [31:0] timer_reg;
    logic        irq_reg;
    logic [31:0] cycle_reg;

    // The wrapper already did the window select; upper address bits are don't-care here.
    logic unused_bits;
    assign unused_bits = ^{data_addr_i[31:5], data_be_i[3:1]};

    assign sel         = decode_offset(data_addr_i[4:0]);
    assign print_store = data_we_i && (sel == VP_PRINT);

    // Full is registered state, so print_ready_i never reaches the grant.
    assign data_gnt_o = data_req_i && core_rst_n && !(print_store && fifo_full);
    assign accept     = data_req_i && data_gnt_o;
    assign wr         = accept && data_we_i;
    assign rd         = accept && !data_we_i;

    assign fifo_push = wr && (sel == VP_PRINT) && data_be_i[0];
    assign fifo_pop  = !fifo_empty && print_ready_i;

    tb_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .push       (fifo_push),
        .push_data  (data_wdata_i[7:0]),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        read_data = '0;
        case (sel)
            VP_PRINT: read_data = 32'(fifo_count);
            VP_TIMER: read_data = timer_reg;
            VP_CYCLE: read_data = cycle_reg;
            default:  read_data = '0;
        endcase
    end

    // Single-entry response stage: every accept produces exactly one rvalid next cycle.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= accept;
            rdata_reg  <= rd ? read_data : '0;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            passed_reg     <= 1'b0;
            failed_reg     <= 1'b0;
            exit_valid_reg <= 1'b0;
            exit_value_reg <= '0;
        end else begin
            if (wr && sel == VP_TEST_STATUS) begin
                if (data_wdata_i == PASS_MAGIC) begin
                    passed_reg <= 1'b1;
                end else if (data_wdata_i != '0) begin
                    failed_reg <= 1'b1;
                end
            end
            // First exit code wins; later writes are ignored.
            if (wr && sel == VP_EXIT && !exit_valid_reg) begin
                exit_valid_reg <= 1'b1;
                exit_value_reg <= data_wdata_i;
            end
        end
    end

    // A load in the expiry cycle takes priority, so the irq is never raised for it.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            timer_reg <= '0;
            irq_reg   <= 1'b0;
        end else if (wr && sel == VP_TIMER) begin
            timer_reg <= data_wdata_i;
            irq_reg   <= 1'b0;
        end else if (timer_reg != '0) begin
            timer_reg <= timer_reg - 32'd1;
            if (timer_reg == 32'd1) begin
                irq_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    assign data_rvalid_o  = rvalid_reg;
    assign data_rdata_o   = rdata_reg;
    assign print_valid_o  = !fifo_empty;
    assign print_char_o   = fifo_empty ? 8'h00 : fifo_head;
    assign irq_timer_o    = irq_reg;
    assign tests_passed_o = passed_reg;
    assign tests_failed_o = failed_reg;
    assign exit_valid_o   = exit_valid_reg;
    assign exit_value_o   = exit_value_reg;

endmodule

// File: tb/tb_cv32e40x_tb_virt_periph.sv
// Scoreboard bench for the virtual peripheral: the driver queues expected responses and
// characters, a negedge monitor pops and compares them as the DUT presents them.
module tb_cv32e40x_tb_virt_periph;
    import tb_vp_pkg::*;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;

    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        print_valid;
    logic        print_ready = 1'b0;
    logic [7:0]  print_char;
    logic        irq_timer;
    logic        tests_passed;
    logic        tests_failed;
    logic        exit_valid;
    logic [31:0] exit_value;

    always #5 core_clk = ~core_clk;

    cv32e40x_tb_virt_periph dut (
        .core_clk       (core_clk),
        .core_rst_n     (core_rst_n),
        .data_req_i     (req),
        .data_gnt_o     (gnt),
        .data_addr_i    (addr),
        .data_we_i      (we),
        .data_be_i      (be),
        .data_wdata_i   (wdata),
        .data_rvalid_o  (rvalid),
        .data_rdata_o   (rdata),
        .print_valid_o  (print_valid),
        .print_ready_i  (print_ready),
        .print_char_o   (print_char),
        .irq_timer_o    (irq_timer),
        .tests_passed_o (tests_passed),
        .tests_failed_o (tests_failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    string       sb_name[$];
    logic [7:0]  cq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_printed = 0;
    logic [31:0] last_rdata = '0;
    logic        acc_prev;
    rsp_t        mon_e;
    string       mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        n_checks++;
        if (act !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_val);
        end
    endtask

    always @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) acc_prev <= 1'b0;
        else             acc_prev <= req & gnt;
    end

    // Monitor: response timing, scoreboard pops and character stream.
    always @(negedge core_clk) begin
        #2;
        check("rvalid_one_cycle_after_accept", {31'b0, rvalid}, {31'b0, acc_prev});
        if (rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rvalid, expected no response");
            end else begin
                mon_e    = sb.pop_front();
                mon_name = sb_name.pop_front();
                last_rdata = rdata;
                if (mon_e.chk) check(mon_name, rdata, mon_e.data);
                $display("rsp %s rdata=0x%08h", mon_name, rdata);
            end
        end
        if (print_valid && print_ready) begin
            n_printed++;
            if (cq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL print_unexpected: got char 0x%02h, expected none", print_char);
            end else begin
                check("print_char", {24'b0, print_char}, {24'b0, cq.pop_front()});
            end
        end
    end

    // One bus transaction; with release_ready the grant is first required low, then ready is raised.
    task automatic bus_op(input logic op_we, input logic [4:0] ofs, input logic [31:0] op_wdata,
                          input logic chk, input logic [31:0] exp_val, input string name,
                          input logic release_ready = 1'b0);
        int waits = 0;
        @(negedge core_clk);
        req   = 1'b1;
        addr  = BASE | {27'b0, ofs};
        we    = op_we;
        wdata = op_wdata;
        be    = 4'hF;
        #1;
        if (release_ready) begin
            check("gnt_low_when_full", {31'b0, gnt}, 32'd0);
            print_ready = 1'b1;
        end
        while (!gnt && waits < 50) begin
            @(negedge core_clk);
            #1;
            waits++;
        end
        if (!gnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no grant in 50 cycles, expected grant", name);
            req = 1'b0;
            return;
        end
        sb.push_back({chk, exp_val});
        sb_name.push_back(name);
        if (op_we && ofs == OFS_PRINT) cq.push_back(op_wdata[7:0]);
        @(posedge core_clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_print_valid"}, {31'b0, print_valid}, 32'd0);
        check({tag, "_print_char"}, {24'b0, print_char}, 32'd0);
        check({tag, "_irq"}, {31'b0, irq_timer}, 32'd0);
        check({tag, "_passed"}, {31'b0, tests_passed}, 32'd0);
        check({tag, "_failed"}, {31'b0, tests_failed}, 32'd0);
        check({tag, "_exit_valid"}, {31'b0, exit_valid}, 32'd0);
        check({tag, "_exit_value"}, exit_value, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1;
        logic [31:0] c2;

        // Reset state and no grant while in reset
        idle(2);
        req  = 1'b1;
        addr = BASE | 32'h0;
        #1;
        check("gnt_in_reset", {31'b0, gnt}, 32'd0);
        req = 1'b0;
        check_all_zero("reset");
        @(negedge core_clk);
        core_rst_n = 1'b1;

        // Status register
        bus_op(1'b1, OFS_TEST_STATUS, MAGIC, 1'b0, 32'd0, "st_pass");
        check("passed_after_magic", {31'b0, tests_passed}, 32'd1);
        check("failed_after_magic", {31'b0, tests_failed}, 32'd0);
        bus_op(1'b1, OFS_TEST_STATUS, 32'd0, 1'b0, 32'd0, "st_zero");
        check("failed_after_zero", {31'b0, tests_failed}, 32'd0);
        bus_op(1'b1, OFS_TEST_STATUS, 32'h0000_DEAD, 1'b0, 32'd0, "st_fail");
        check("failed_after_nonmagic", {31'b0, tests_failed}, 32'd1);
        check("passed_sticky", {31'b0, tests_passed}, 32'd1);

        // Exit register: first write sticks
        bus_op(1'b1, OFS_EXIT, 32'h2A, 1'b0, 32'd0, "exit_2a");
        check("exit_valid", {31'b0, exit_valid}, 32'd1);
        check("exit_value", exit_value, 32'h2A);
        bus_op(1'b1, OFS_EXIT, 32'h0, 1'b0, 32'd0, "exit_0");
        check("exit_value_kept", exit_value, 32'h2A);

        // Print FIFO: fill, stall ninth store, drain in order
        for (int i = 0; i < 8; i++) begin
            bus_op(1'b1, OFS_PRINT, 32'h41 + 32'(i), 1'b0, 32'd0, "print_store");
        end
        bus_op(1'b0, OFS_PRINT, 32'd0, 1'b1, 32'd8, "print_count_full");
        bus_op(1'b1, OFS_PRINT, 32'h49, 1'b0, 32'd0, "print_store_9th", 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge core_clk);
            #3;
            if (!print_valid && cq.size() == 0) break;
        end
        check("print_drained", {31'b0, print_valid}, 32'd0);
        check("print_total", 32'(n_printed), 32'd9);
        bus_op(1'b0, OFS_PRINT, 32'd0, 1'b1, 32'd0, "print_count_empty");

        // Timer: expiry three cycles after load, clear by writing 0
        bus_op(1'b1, OFS_TIMER, 32'd3, 1'b0, 32'd0, "timer_3");
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            #1;
            check("irq_before_expiry", {31'b0, irq_timer}, 32'd0);
        end
        @(negedge core_clk);
        #1;
        check("irq_at_expiry", {31'b0, irq_timer}, 32'd1);
        bus_op(1'b0, OFS_TIMER, 32'd0, 1'b1, 32'd0, "timer_read_expired");
        check("irq_holds", {31'b0, irq_timer}, 32'd1);
        bus_op(1'b1, OFS_TIMER, 32'd0, 1'b0, 32'd0, "timer_0");
        check("irq_cleared", {31'b0, irq_timer}, 32'd0);

        // Timer write coincident with expiry
        bus_op(1'b1, OFS_TIMER, 32'd2, 1'b0, 32'd0, "timer_2");
        idle(1);
        bus_op(1'b1, OFS_TIMER, 32'd7, 1'b0, 32'd0, "timer_7_at_expiry");
        check("irq_coincident", {31'b0, irq_timer}, 32'd0);
        bus_op(1'b0, OFS_TIMER, 32'd0, 1'b1, 32'd7, "timer_read_reload");
        check("irq_after_reload", {31'b0, irq_timer}, 32'd0);
        bus_op(1'b1, OFS_TIMER, 32'd0, 1'b0, 32'd0, "timer_idle");

        // Cycle counter: two loads five cycles apart
        bus_op(1'b0, OFS_CYCLE, 32'd0, 1'b0, 32'd0, "cycle_a");
        idle(4);
        c1 = last_rdata;
        bus_op(1'b0, OFS_CYCLE, 32'd0, 1'b0, 32'd0, "cycle_b");
        @(negedge core_clk);
        #3;
        c2 = last_rdata;
        check("cycle_delta", c2 - c1, 32'd5);

        // Unmapped offset
        bus_op(1'b0, 5'h14, 32'd0, 1'b1, 32'd0, "unmapped_read");
        bus_op(1'b1, 5'h14, 32'hFFFF_FFFF, 1'b0, 32'd0, "unmapped_write");
        check("unmapped_passed", {31'b0, tests_passed}, 32'd1);
        check("unmapped_failed", {31'b0, tests_failed}, 32'd1);
        check("unmapped_exit", exit_value, 32'h2A);
        check("unmapped_irq", {31'b0, irq_timer}, 32'd0);
        bus_op(1'b0, OFS_PRINT, 32'd0, 1'b1, 32'd0, "unmapped_print_count");
        bus_op(1'b0, OFS_TIMER, 32'd0, 1'b1, 32'd0, "unmapped_timer");

        // Reset with a load in flight and a buffered character
        print_ready = 1'b0;
        bus_op(1'b1, OFS_PRINT, 32'h5A, 1'b0, 32'd0, "print_before_reset");
        bus_op(1'b0, OFS_CYCLE, 32'd0, 1'b0, 32'd0, "load_during_reset");
        core_rst_n = 1'b0;
        sb.delete();
        sb_name.delete();
        cq.delete();
        #1;
        check_all_zero("midreset");
        idle(2);
        core_rst_n = 1'b1;
        bus_op(1'b0, OFS_PRINT, 32'd0, 1'b1, 32'd0, "print_count_post_reset");
        idle(2);
        check("sb_empty_at_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
